// File: rtl/sampler_pkg.sv
// Shared defaults and FSM state encoding for the sample packer.
package sampler_pkg;

  localparam int unsigned WORD_W_DEF     = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered output stage and a valid/ready read port.
module sync_fifo #(
  parameter int unsigned W     = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  output logic                     drop_c,
  output logic [W-1:0]             rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] level_q, level_d;
  logic [W-1:0]     rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             full_c, pop_c, wr_en_c;

  // Output register mirrors the head slot; it counts as buffered until popped.
  always_comb begin
    mem_d      = mem_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    full_c     = (wr_cnt_q - rd_cnt_q) == CNT_W'(DEPTH);
    pop_c      = rd_valid_q & rd_ready;
    wr_en_c    = push & (~full_c | pop_c);
    drop_c     = push & full_c & ~pop_c;
    wr_cnt_d   = wr_cnt_q + CNT_W'(wr_en_c);
    rd_cnt_d   = rd_cnt_q + CNT_W'(pop_c);
    if (wr_en_c) begin
      mem_d[wr_cnt_q[PTR_W-1:0]] = push_data;
    end
    if (~rd_valid_q | pop_c) begin
      rd_valid_d = (wr_cnt_q != rd_cnt_d);
      rd_data_d  = mem_q[rd_cnt_d[PTR_W-1:0]];
    end
    level_d = wr_cnt_d - rd_cnt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign level    = level_q;

endmodule

// File: rtl/sample_packer.sv
// Samples din on rising edges of the divided clock (treated as data) while flag
// is high, packs bits MSB-first into words and queues them for a downstream reader.
module sample_packer
  import sampler_pkg::*;
#(
  parameter int unsigned WORD_W     = WORD_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flag,
  input  logic                          clk_local,
  input  logic                          din,
  output logic [WORD_W-1:0]             dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          dout_last,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned CNT_W = $clog2(WORD_W + 1);

  state_e            state_q, state_d;
  logic              cl_q, cl_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              overflow_q, overflow_d;
  logic              tick_c, push_c, push_last_c, drop_c;
  logic [WORD_W-1:0] push_word_c;

  // Tick detect, window FSM and bit packing.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    overflow_d  = overflow_q | drop_c;
    push_c      = 1'b0;
    push_last_c = 1'b0;
    push_word_c = shreg_q;
    cl_d        = clk_local;
    tick_c      = clk_local & ~cl_q & flag;

    case (state_q)
      IDLE: begin
        if (flag) begin
          state_d    = RUN;
          cnt_d      = '0;
          shreg_d    = '0;
          overflow_d = 1'b0;
        end
      end
      RUN: begin
        if (!flag) begin
          // Window closed: flush any partial word left-aligned, zero-padded.
          state_d = IDLE;
          cnt_d   = '0;
          if (cnt_q != '0) begin
            push_c      = 1'b1;
            push_last_c = 1'b1;
            push_word_c = shreg_q << (CNT_W'(WORD_W) - cnt_q);
          end
        end else begin
          if (cnt_q == CNT_W'(WORD_W)) begin
            push_c = 1'b1;
            cnt_d  = '0;
          end
          if (tick_c) begin
            shreg_d = {shreg_q[WORD_W-2:0], din};
            cnt_d   = cnt_d + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cl_q       <= 1'b0;
      shreg_q    <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cl_q       <= cl_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .W     (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data ({push_last_c, push_word_c}),
    .drop_c    (drop_c),
    .rd_data   ({dout_last, dout}),
    .rd_valid  (dout_valid),
    .rd_ready  (dout_ready),
    .level     (fifo_level)
  );

  assign overflow = overflow_q;

endmodule

// File: tb/tb_sample_packer.sv
// Directed and randomized checks of sample_packer against a word-level model.
`timescale 1ns/1ps
module tb_sample_packer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       flag = 1'b0;
  logic       clk_local = 1'b0;
  logic       din = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       dout_last;
  logic       overflow;
  logic [2:0] fifo_level;

  int checks = 0;
  int failures = 0;
  int ready_mode = 0;  // 0: ready low, 1: ready high, 2: random

  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  bit         win_bits[$];

  sample_packer #(.WORD_W(8), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flag       (flag),
    .clk_local  (clk_local),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #125 clk = ~clk;

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance to the next falling edge, drive ready and log any pop at the next rise.
  task automatic step();
    @(negedge clk);
    case (ready_mode)
      0:       dout_ready = 1'b0;
      1:       dout_ready = 1'b1;
      default: dout_ready = 1'($urandom_range(0, 1));
    endcase
    if (dout_valid && dout_ready) got_q.push_back({dout_last, dout});
  endtask

  task automatic send_bit(input bit b);
    clk_local = 1'b1;
    din = b;
    if (flag) win_bits.push_back(b);
    step(); step();
    clk_local = 1'b0;
    step(); step();
  endtask

  task automatic open_window();
    flag = 1'b1;
    step(); step();
  endtask

  // Reference: chop the window's bits into MSB-first words; a short tail is padded and marked last.
  task automatic close_model();
    int n;
    int k;
    logic [7:0] w;
    n = win_bits.size();
    for (int i = 0; i < n; i += 8) begin
      w = '0;
      k = (n - i < 8) ? n - i : 8;
      for (int j = 0; j < k; j++) w[7-j] = win_bits[i+j];
      exp_q.push_back({(k < 8) ? 1'b1 : 1'b0, w});
    end
    win_bits.delete();
  endtask

  task automatic close_window();
    flag = 1'b0;
    step(); step(); step();
    close_model();
  endtask

  task automatic drain_and_compare(input string tag);
    int n;
    ready_mode = 1;
    for (int i = 0; i < 200 && (dout_valid || fifo_level != 0); i++) step();
    ready_mode = 0;
    step();
    chk({tag, "_drained"}, 32'(fifo_level), 32'd0);
    chk({tag, "_nwords"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bit b;
    int nb;

    // Reset state
    #10 rst_n = 1'b0;
    #1;
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_last", 32'(dout_last), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // 1: pattern 1,0,1,1,0,0,1,0 -> 8'hB2, valid two cycles after the 8th tick
    open_window();
    send_bit(1); send_bit(0); send_bit(1); send_bit(1);
    send_bit(0); send_bit(0); send_bit(1);
    clk_local = 1'b1; din = 1'b0; win_bits.push_back(1'b0);
    step();
    step();
    chk("t1_valid_early", 32'(dout_valid), 32'd0);
    chk("t1_level_pushed", 32'(fifo_level), 32'd1);
    clk_local = 1'b0;
    step();
    chk("t1_valid", 32'(dout_valid), 32'd1);
    chk("t1_dout", 32'(dout), 32'hB2);
    chk("t1_last", 32'(dout_last), 32'd0);
    step();
    close_window();
    chk("t1_no_flush", 32'(fifo_level), 32'd1);
    drain_and_compare("t1");

    // 2: three ones then flag drops -> 8'hE0 with last; next window starts clean
    open_window();
    send_bit(1); send_bit(1); send_bit(1);
    close_window();
    chk("t2_valid", 32'(dout_valid), 32'd1);
    chk("t2_word", 32'({dout_last, dout}), 32'h1E0);
    drain_and_compare("t2");
    open_window();
    for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
    close_window();
    drain_and_compare("t2_clean");

    // 3: five words with ready low -> full, overflow, first four kept
    open_window();
    for (int i = 0; i < 40; i++) send_bit(1'($urandom_range(0, 1)));
    step(); step();
    chk("t3_level", 32'(fifo_level), 32'd4);
    chk("t3_overflow", 32'(overflow), 32'd1);
    close_window();
    while (exp_q.size() > 4) void'(exp_q.pop_back());
    drain_and_compare("t3");

    // 4: push and pop in the same cycle while full
    open_window();
    chk("t4_ovf_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 39; i++) send_bit(1'($urandom_range(0, 1)));
    chk("t4_full", 32'(fifo_level), 32'd4);
    b = 1'($urandom_range(0, 1));
    clk_local = 1'b1; din = b; win_bits.push_back(b);
    ready_mode = 1;
    step();
    ready_mode = 0;
    step();
    chk("t4_level", 32'(fifo_level), 32'd4);
    chk("t4_overflow", 32'(overflow), 32'd0);
    clk_local = 1'b0;
    step(); step();
    close_window();
    drain_and_compare("t4");

    // 5: reset mid-word and mid-handshake
    open_window();
    for (int i = 0; i < 19; i++) send_bit(1'($urandom_range(0, 1)));
    ready_mode = 1;
    step();
    rst_n = 1'b0;
    #1;
    chk("t5_valid", 32'(dout_valid), 32'd0);
    chk("t5_level", 32'(fifo_level), 32'd0);
    chk("t5_overflow", 32'(overflow), 32'd0);
    ready_mode = 0;
    flag = 1'b0;
    clk_local = 1'b0;
    dout_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    got_q.delete(); exp_q.delete(); win_bits.delete();
    step();
    open_window();
    for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
    close_window();
    drain_and_compare("t5");

    // 6: hold valid with ready low for 10 cycles, then random ready over random windows
    open_window();
    for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)));
    close_window();
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("t6_hold_valid%0d", i), 32'(dout_valid), 32'd1);
      chk($sformatf("t6_hold_word%0d", i), 32'({dout_last, dout}), 32'(exp_q[0]));
    end
    drain_and_compare("t6_hold");
    ready_mode = 2;
    for (int w = 0; w < 6; w++) begin
      open_window();
      nb = $urandom_range(1, 30);
      for (int i = 0; i < nb; i++) send_bit(1'($urandom_range(0, 1)));
      close_window();
    end
    chk("t6_overflow", 32'(overflow), 32'd0);
    drain_and_compare("t6_rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
